ps2_direction_decoder: RTL and testbench

- Upstream input stage for the Tron game core: receives PS/2 keyboard frames and decodes them into per-player one-hot direction vectors.
- Inputs are the raw keyboardCLK and keyboardData lines; direction1 and direction2 feed the snake update logic.
- Provides synchronisation, glitch filtering, parity, stop-bit and timeout checks, break/extended code handling, and a reverse-direction guard.

---
 rtl/ps2_direction_decoder.sv | 182 ++++++++++++++++++
 tb/tb_ps2_direction_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_direction_decoder.sv
// PS/2 receiver for the Tron core: sync, clock filter, frame checks,
// and per-player one-hot direction decode with a reverse guard.
module ps2_direction_decoder #(
  parameter int          FILTER_LEN     = 8,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [4:0]  DEF_DIR1       = 5'b10000,
  parameter logic [4:0]  DEF_DIR2       = 5'b00100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyboardCLK,
  input  logic       keyboardData,
  input  logic       start,
  output logic [4:0] direction1,
  output logic [4:0] direction2,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, stateNext;

  logic [1:0]            clkSync, datSync;
  logic [FILTER_LEN-1:0] clkHist;
  logic                  clkFilt, clkFiltQ;
  logic                  fall, dataBit;
  logic [2:0]            bitCnt, bitCntNext;
  logic [7:0]            shiftReg, shiftNext;
  logic                  parBit, parNext;
  logic [TW-1:0]         toCnt, toNext;
  logic                  byteDone, byteOk, timeout;
  logic                  brkFlag, extFlag;
  logic [4:0]            req1, req2;

  function automatic logic [4:0] opp(input logic [4:0] d);
    return {d[2], d[1], d[4], d[3], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      clkSync  <= 2'b11;
      datSync  <= 2'b11;
      clkHist  <= '1;
      clkFilt  <= 1'b1;
      clkFiltQ <= 1'b1;
    end else begin
      clkSync  <= {clkSync[0], keyboardCLK};
      datSync  <= {datSync[0], keyboardData};
      clkHist  <= {clkHist[FILTER_LEN-2:0], clkSync[1]};
      if (&clkHist)
        clkFilt <= 1'b1;
      else if (~|clkHist)
        clkFilt <= 1'b0;
      clkFiltQ <= clkFilt;
    end
  end

  assign fall    = clkFiltQ & ~clkFilt;
  assign dataBit = datSync[1];

  // A strobe always clears the watchdog, so it beats a same-cycle timeout
  always_comb begin
    stateNext  = state;
    bitCntNext = bitCnt;
    shiftNext  = shiftReg;
    parNext    = parBit;
    toNext     = toCnt;
    byteDone   = 1'b0;
    byteOk     = 1'b0;
    timeout    = 1'b0;
    if (fall) begin
      toNext = '0;
      unique case (state)
        IDLE: begin
          if (!dataBit) begin
            stateNext  = DATA;
            bitCntNext = 3'd0;
          end
        end
        DATA: begin
          shiftNext  = {dataBit, shiftReg[7:1]};
          bitCntNext = bitCnt + 3'd1;
          if (bitCnt == 3'd7)
            stateNext = PARITY;
        end
        PARITY: begin
          parNext   = dataBit;
          stateNext = STOP;
        end
        STOP: begin
          byteDone  = 1'b1;
          byteOk    = dataBit & (^{shiftReg, parBit});
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout   = 1'b1;
        stateNext = IDLE;
        toNext    = '0;
      end else begin
        toNext = toCnt + TW'(1);
      end
    end else begin
      toNext = '0;
    end
  end

  always_comb begin
    req1 = 5'b00000;
    req2 = 5'b00000;
    if (byteOk && !brkFlag && !extFlag) begin
      case (shiftReg)
        8'h1D:   req1 = 5'b00010;
        8'h1C:   req1 = 5'b00100;
        8'h1B:   req1 = 5'b01000;
        8'h23:   req1 = 5'b10000;
        8'h43:   req2 = 5'b00010;
        8'h3B:   req2 = 5'b00100;
        8'h42:   req2 = 5'b01000;
        8'h4B:   req2 = 5'b10000;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bitCnt     <= 3'd0;
      shiftReg   <= 8'h00;
      parBit     <= 1'b0;
      toCnt      <= '0;
      key_code   <= 8'h00;
      key_valid  <= 1'b0;
      frame_err  <= 1'b0;
      brkFlag    <= 1'b0;
      extFlag    <= 1'b0;
      direction1 <= DEF_DIR1;
      direction2 <= DEF_DIR2;
    end else begin
      state     <= stateNext;
      bitCnt    <= bitCntNext;
      shiftReg  <= shiftNext;
      parBit    <= parNext;
      toCnt     <= toNext;
      key_valid <= byteOk;
      frame_err <= (byteDone & ~byteOk) | timeout;
      if (byteOk) begin
        key_code <= shiftReg;
        if (shiftReg == 8'hF0) begin
          brkFlag <= 1'b1;
        end else if (shiftReg == 8'hE0) begin
          extFlag <= 1'b1;
        end else begin
          brkFlag <= 1'b0;
          extFlag <= 1'b0;
        end
      end
      if (!start) begin
        direction1 <= DEF_DIR1;
        direction2 <= DEF_DIR2;
      end else begin
        if ((|req1) && (req1 != opp(direction1)))
          direction1 <= req1;
        if ((|req2) && (req2 != opp(direction2)))
          direction2 <= req2;
      end
    end
  end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench for ps2_direction_decoder with a byte-level model
// of key decode and direction rules.
module tb_ps2_direction_decoder;

  localparam int H  = 30;
  localparam int TO = 500;

  logic       clk = 1'b0;
  logic       reset, keyboardCLK, keyboardData, start;
  logic [4:0] direction1, direction2;
  logic [7:0] key_code;
  logic       key_valid, frame_err;

  int errors = 0;
  int checks = 0;
  int kvSeen = 0;
  int errSeen = 0;
  bit busy = 1'b1;

  // Directions as 0 up, 1 left, 2 down, 3 right; opposite is +2 mod 4
  int         mDir1, mDir2;
  logic [7:0] mCode;
  bit         mBrk, mExt, mStart;

  always #10 clk = ~clk;

  ps2_direction_decoder #(
    .FILTER_LEN(8),
    .TIMEOUT_CYCLES(TO),
    .DEF_DIR1(5'b10000),
    .DEF_DIR2(5'b00100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .keyboardCLK(keyboardCLK),
    .keyboardData(keyboardData),
    .start(start),
    .direction1(direction1),
    .direction2(direction2),
    .key_code(key_code),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  function automatic logic [4:0] hot(input int d);
    return 5'(1 << (d + 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid) kvSeen++;
    if (frame_err) errSeen++;
    if (!busy) begin
      chk("dir1", 32'(direction1), 32'(hot(mDir1)));
      chk("dir2", 32'(direction2), 32'(hot(mDir2)));
      chk("key_code", 32'(key_code), 32'(mCode));
      chk("idle_key_valid", 32'(key_valid), 32'd0);
      chk("idle_frame_err", 32'(frame_err), 32'd0);
    end
  end

  task automatic modelReset();
    mDir1 = 3;
    mDir2 = 1;
    mCode = 8'h00;
    mBrk  = 1'b0;
    mExt  = 1'b0;
  endtask

  task automatic applyByte(input logic [7:0] b);
    int pl, d;
    mCode = b;
    pl = 0;
    d  = 0;
    case (b)
      8'h1D: begin pl = 1; d = 0; end
      8'h1C: begin pl = 1; d = 1; end
      8'h1B: begin pl = 1; d = 2; end
      8'h23: begin pl = 1; d = 3; end
      8'h43: begin pl = 2; d = 0; end
      8'h3B: begin pl = 2; d = 1; end
      8'h42: begin pl = 2; d = 2; end
      8'h4B: begin pl = 2; d = 3; end
      default: ;
    endcase
    if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else if (b == 8'hE0) begin
      mExt = 1'b1;
    end else if (mBrk || mExt) begin
      mBrk = 1'b0;
      mExt = 1'b0;
    end else if (mStart) begin
      if (pl == 1 && d != (mDir1 + 2) % 4) mDir1 = d;
      if (pl == 2 && d != (mDir2 + 2) % 4) mDir2 = d;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2Bit(input logic v, input bit glitch);
    keyboardCLK = 1'b1;
    tick(10);
    keyboardData = v;
    if (glitch) begin
      tick(5);
      keyboardCLK = 1'b0;
      tick(5);
      keyboardCLK = 1'b1;
      tick(10);
    end else begin
      tick(20);
    end
    keyboardCLK = 1'b0;
    tick(H);
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit badPar,
                           input bit badStop, input bit glitch);
    int kv0, e0;
    bit ok;
    kv0  = kvSeen;
    e0   = errSeen;
    busy = 1'b1;
    ps2Bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2Bit(b[i], glitch);
    ps2Bit((~^b) ^ badPar, glitch);
    ps2Bit(~badStop, glitch);
    keyboardCLK  = 1'b1;
    keyboardData = 1'b1;
    tick(20);
    ok = !badPar && !badStop;
    if (ok) applyByte(b);
    chk("kv_pulses", 32'(kvSeen - kv0), 32'(ok));
    chk("err_pulses", 32'(errSeen - e0), 32'(!ok));
    busy = 1'b0;
    tick(5);
  endtask

  initial begin
    int kv0, e0;
    reset        = 1'b1;
    start        = 1'b1;
    mStart       = 1'b1;
    keyboardCLK  = 1'b1;
    keyboardData = 1'b1;
    modelReset();
    tick(5);
    reset = 1'b0;
    tick(3);
    busy = 1'b0;
    tick(100);
    chk("rst_dir1", 32'(direction1), 32'h10);
    chk("rst_dir2", 32'(direction2), 32'h04);
    chk("rst_code", 32'(key_code), 32'h00);

    sendFrame(8'h1D, 0, 0, 0);
    chk("up1_dir1", 32'(direction1), 32'h02);
    chk("up1_code", 32'(key_code), 32'h1D);
    chk("up1_dir2", 32'(direction2), 32'h04);
    sendFrame(8'h23, 0, 0, 0);
    sendFrame(8'h1C, 0, 0, 0);
    chk("rev_dir1", 32'(direction1), 32'h10);
    sendFrame(8'h1B, 0, 0, 0);
    chk("down_dir1", 32'(direction1), 32'h08);

    sendFrame(8'hF0, 0, 0, 0);
    sendFrame(8'h43, 0, 0, 0);
    chk("brk_dir2", 32'(direction2), 32'h04);
    sendFrame(8'h43, 0, 0, 0);
    chk("up_dir2", 32'(direction2), 32'h02);

    sendFrame(8'h23, 1, 0, 0);
    sendFrame(8'h23, 0, 1, 0);
    chk("bad_code", 32'(key_code), 32'h43);

    kv0  = kvSeen;
    e0   = errSeen;
    busy = 1'b1;
    ps2Bit(1'b0, 0);
    ps2Bit(1'b1, 0);
    ps2Bit(1'b0, 0);
    ps2Bit(1'b1, 0);
    ps2Bit(1'b1, 0);
    keyboardCLK  = 1'b1;
    keyboardData = 1'b1;
    tick(TO + 100);
    chk("to_err", 32'(errSeen - e0), 32'd1);
    chk("to_kv", 32'(kvSeen - kv0), 32'd0);
    busy = 1'b0;
    tick(5);

    sendFrame(8'h4B, 0, 0, 0);
    chk("right_dir2", 32'(direction2), 32'h10);
    sendFrame(8'h42, 0, 0, 1);
    chk("glitch_dir2", 32'(direction2), 32'h08);
    chk("glitch_code", 32'(key_code), 32'h42);

    busy   = 1'b1;
    start  = 1'b0;
    mStart = 1'b0;
    mDir1  = 3;
    mDir2  = 1;
    tick(3);
    busy = 1'b0;
    sendFrame(8'h42, 0, 0, 0);
    chk("stop_dir2", 32'(direction2), 32'h04);

    busy   = 1'b1;
    start  = 1'b1;
    mStart = 1'b1;
    tick(3);
    busy = 1'b0;
    sendFrame(8'h1C, 0, 0, 0);
    chk("restart_rev", 32'(direction1), 32'h10);
    sendFrame(8'h3B, 0, 0, 0);
    sendFrame(8'h4B, 0, 0, 0);
    chk("restart_rev2", 32'(direction2), 32'h04);

    kv0  = kvSeen;
    e0   = errSeen;
    busy = 1'b1;
    ps2Bit(1'b0, 0);
    ps2Bit(1'b1, 0);
    ps2Bit(1'b1, 0);
    reset = 1'b1;
    tick(3);
    reset        = 1'b0;
    keyboardCLK  = 1'b1;
    keyboardData = 1'b1;
    modelReset();
    tick(TO + 100);
    chk("midrst_err", 32'(errSeen - e0), 32'd0);
    chk("midrst_kv", 32'(kvSeen - kv0), 32'd0);
    busy = 1'b0;
    tick(5);
    sendFrame(8'h1D, 0, 0, 0);
    chk("midrst_dir1", 32'(direction1), 32'h02);
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
